// File: rtl/timer_channels.sv
// Multi-channel prescaled timer with a byte-addressed register interface.
// Each channel has CTRL/MAX/CNT/STAT registers, an 8-bit prescaler, an
// up-counter that expires at MAX, a sticky status bit and a level interrupt.
module timer_channels #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      addr,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic            mod_en,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] irq,
    output logic [N_CH-1:0] expire
);

    // Register offsets within a channel window, as word index addr[3:2].
    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_MAX  = 2'd1;
    localparam logic [1:0] REG_CNT  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    logic                       wr_c;
    logic                       rd_c;
    logic                       aligned_c;
    logic [1:0]                 ch_c;
    logic [1:0]                 reg_c;
    logic [N_CH-1:0]            ch_hit_c;

    logic [N_CH-1:0]            en_w;
    logic [N_CH-1:0]            mode_w;
    logic [N_CH-1:0]            irq_en_w;
    logic [N_CH-1:0][7:0]       presc_w;
    logic [N_CH-1:0][CNT_W-1:0] max_w;
    logic [N_CH-1:0][CNT_W-1:0] cnt_w;
    logic [N_CH-1:0]            stat_w;
    logic [N_CH-1:0]            expire_w;

    logic [31:0]                rmux_c;
    logic [31:0]                rdata_q;
    logic [31:0]                rdata_d;

    // Only some wdata bits land in registers; fold the rest so none dangle.
    logic                       unused_wdata;
    assign unused_wdata = ^wdata;

    // Access qualification and address decode; unaligned or out-of-range
    // channel addresses hit nothing.
    always_comb begin
        wr_c      = wr_en && mod_en;
        rd_c      = rd_en && mod_en;
        ch_c      = addr[5:4];
        reg_c     = addr[3:2];
        aligned_c = (addr[1:0] == 2'b00);
        for (int c = 0; c < int'(N_CH); c++) begin
            ch_hit_c[c] = aligned_c && (ch_c == 2'(c));
        end
    end

    for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
        logic             wr_ctrl_c;
        logic             wr_max_c;
        logic             wr_cnt_c;
        logic             wr_stat_c;
        logic             tick_c;
        logic             at_max_c;
        logic             expiry_c;

        logic             en_q,     en_d;
        logic             mode_q,   mode_d;
        logic             irq_en_q, irq_en_d;
        logic [7:0]       presc_q,  presc_d;
        logic [7:0]       psc_q,    psc_d;
        logic [CNT_W-1:0] max_q,    max_d;
        logic [CNT_W-1:0] cnt_q,    cnt_d;
        logic             stat_q,   stat_d;
        logic             expire_q, expire_d;

        // Per-register write strobes and tick/expiry qualification.
        always_comb begin
            wr_ctrl_c = wr_c && ch_hit_c[c] && (reg_c == REG_CTRL);
            wr_max_c  = wr_c && ch_hit_c[c] && (reg_c == REG_MAX);
            wr_cnt_c  = wr_c && ch_hit_c[c] && (reg_c == REG_CNT);
            wr_stat_c = wr_c && ch_hit_c[c] && (reg_c == REG_STAT);
            tick_c    = en_q && (psc_q == presc_q);
            // Compared against the pre-write MAX; a CNT write suppresses expiry.
            at_max_c  = (cnt_q == max_q);
            expiry_c  = tick_c && at_max_c && !wr_cnt_c;
        end

        // Next-state for control, prescaler, counter and status.
        always_comb begin
            en_d     = en_q;
            mode_d   = mode_q;
            irq_en_d = irq_en_q;
            presc_d  = presc_q;
            psc_d    = psc_q;
            max_d    = max_q;
            cnt_d    = cnt_q;
            stat_d   = stat_q;
            expire_d = expiry_c;

            // Prescaler runs only while enabled and wraps after matching presc.
            if (en_q) begin
                psc_d = tick_c ? 8'd0 : psc_q + 8'd1;
            end

            if (wr_ctrl_c) begin
                en_d     = wdata[0];
                mode_d   = wdata[1];
                irq_en_d = wdata[2];
                presc_d  = wdata[15:8];
                // Fresh enable starts a full prescale period.
                if (wdata[0] && !en_q) begin
                    psc_d = 8'd0;
                end
            end else if (expiry_c && mode_q) begin
                en_d = 1'b0;
            end

            if (wr_max_c) begin
                max_d = wdata[CNT_W-1:0];
            end

            // Counter wraps naturally when MAX was lowered below it.
            if (wr_cnt_c) begin
                cnt_d = wdata[CNT_W-1:0];
            end else if (tick_c) begin
                cnt_d = at_max_c ? '0 : cnt_q + CNT_W'(1);
            end

            // Sticky status: W1C, with a coincident expiry taking priority.
            if (wr_stat_c && wdata[0]) begin
                stat_d = 1'b0;
            end
            if (expiry_c) begin
                stat_d = 1'b1;
            end
        end

        // Channel state register.
        always_ff @(posedge clk) begin
            if (rst) begin
                en_q     <= 1'b0;
                mode_q   <= 1'b0;
                irq_en_q <= 1'b0;
                presc_q  <= 8'd0;
                psc_q    <= 8'd0;
                max_q    <= '0;
                cnt_q    <= '0;
                stat_q   <= 1'b0;
                expire_q <= 1'b0;
            end else begin
                en_q     <= en_d;
                mode_q   <= mode_d;
                irq_en_q <= irq_en_d;
                presc_q  <= presc_d;
                psc_q    <= psc_d;
                max_q    <= max_d;
                cnt_q    <= cnt_d;
                stat_q   <= stat_d;
                expire_q <= expire_d;
            end
        end

        assign en_w[c]     = en_q;
        assign mode_w[c]   = mode_q;
        assign irq_en_w[c] = irq_en_q;
        assign presc_w[c]  = presc_q;
        assign max_w[c]    = max_q;
        assign cnt_w[c]    = cnt_q;
        assign stat_w[c]   = stat_q;
        assign expire_w[c] = expire_q;
    end

    // Read mux; anything not hitting a mapped register returns zero.
    always_comb begin
        rmux_c = 32'd0;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (ch_hit_c[c]) begin
                case (reg_c)
                    REG_CTRL: rmux_c = {16'd0, presc_w[c], 5'd0,
                                        irq_en_w[c], mode_w[c], en_w[c]};
                    REG_MAX:  rmux_c = 32'(max_w[c]);
                    REG_CNT:  rmux_c = 32'(cnt_w[c]);
                    default:  rmux_c = {31'd0, stat_w[c]};
                endcase
            end
        end
    end

    // Read data holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_c) begin
            rdata_d = rmux_c;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Outputs: interrupt is a gate of two flops, expiry pulse is a flop.
    always_comb begin
        rdata  = rdata_q;
        irq    = stat_w & irq_en_w;
        expire = expire_w;
    end

endmodule

// File: tb/tb_timer_channels.sv
// Scoreboard bench for timer_channels (N_CH=2, CNT_W=16).
module tb_timer_channels;

    localparam int unsigned N_CH  = 2;
    localparam int unsigned CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [5:0]      addr;
    logic            wr_en;
    logic            rd_en;
    logic            mod_en;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [N_CH-1:0] irq;
    logic [N_CH-1:0] expire;

    int          n_vec  = 0;
    int          n_err  = 0;
    int          n_exp0 = 0;
    int          n_exp1 = 0;
    logic [31:0] sb_exp_q[$];
    string       sb_tag_q[$];

    timer_channels #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .mod_en (mod_en),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq),
        .expire (expire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pop one expected read value per accepted read, one cycle later.
    always @(posedge clk) begin
        if (rd_en && mod_en && !rst) begin
            #1;
            if (sb_exp_q.size() == 0) begin
                check("sb_underflow", 32'(sb_exp_q.size()), 32'd1);
            end else begin
                check(sb_tag_q.pop_front(), rdata, sb_exp_q.pop_front());
            end
        end
    end

    // Count expiry pulses per channel.
    always @(posedge clk) begin
        #1;
        if (expire[0] === 1'b1) n_exp0++;
        if (expire[1] === 1'b1) n_exp1++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic me = 1'b1);
        addr   = a;
        wdata  = d;
        mod_en = me;
        wr_en  = 1'b1;
        @(negedge clk);
        wr_en  = 1'b0;
        mod_en = 1'b1;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string tag);
        addr   = a;
        mod_en = 1'b1;
        rd_en  = 1'b1;
        sb_exp_q.push_back(exp);
        sb_tag_q.push_back(tag);
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        mod_en = 1'b1;
        addr   = 6'd0;
        wdata  = 32'd0;
        repeat (3) @(negedge clk);
        check("rdata_rst0", rdata, 32'd0);
        check("irq_rst0", 32'(irq), 32'd0);
        check("expire_rst0", 32'(expire), 32'd0);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) rd(6'(r * 4), 32'd0, $sformatf("ch0_reg%0d_rst", r));

        // Periodic count to MAX=3, presc 0.
        wr(6'h04, 32'd3);
        wr(6'h00, 32'h5);
        for (int i = 0; i < 6; i++) rd(6'h08, 32'(i % 4), $sformatf("cnt0_run%0d", i));
        check("exp0_first", 32'(n_exp0), 32'd1);
        check("irq0_after_exp", 32'(irq[0]), 32'd1);
        wr(6'h00, 32'h4);
        rd(6'h08, 32'd3, "cnt0_frozen");

        // W1C coincident with expiry: set wins.
        wr(6'h00, 32'h5);
        wr(6'h0C, 32'h1);
        wr(6'h00, 32'h4);
        rd(6'h0C, 32'd1, "stat0_set_wins");
        check("exp0_second", 32'(n_exp0), 32'd2);
        check("irq0_set", 32'(irq[0]), 32'd1);
        wr(6'h0C, 32'h0);
        rd(6'h0C, 32'd1, "stat0_w0_noop");
        wr(6'h0C, 32'h1);
        rd(6'h0C, 32'd0, "stat0_w1c");
        check("irq0_cleared", 32'(irq[0]), 32'd0);

        // Channel 1 one-shot, presc 2, MAX 2: single pulse 9 cycles after enable.
        wr(6'h14, 32'd2);
        wr(6'h10, 32'h0203);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("exp1_cyc%0d", k), 32'(expire[1]), 32'(k == 9));
        end
        check("exp1_count", 32'(n_exp1), 32'd1);
        rd(6'h10, 32'h0202, "ctrl1_oneshot_off");
        rd(6'h18, 32'd0, "cnt1_zero");
        rd(6'h1C, 32'd1, "stat1_set");
        check("irq1_masked", 32'(irq[1]), 32'd0);
        rd(6'h08, 32'd1, "cnt0_indep");

        // CNT write coinciding with a CNT==MAX tick wins, no expiry.
        wr(6'h08, 32'd3);
        wr(6'h00, 32'h1);
        wr(6'h08, 32'h10);
        check("exp0_wr_wins", 32'(expire[0]), 32'd0);
        wr(6'h00, 32'h0);
        rd(6'h08, 32'h11, "cnt0_wr_wins");
        rd(6'h0C, 32'd0, "stat0_no_exp");
        check("exp0_count_wr", 32'(n_exp0), 32'd2);

        // MAX below CNT: wrap through zero silently, then expire at MAX.
        wr(6'h08, 32'hFFFE);
        wr(6'h00, 32'h1);
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            check($sformatf("exp0_wrap%0d", k), 32'(expire[0]), 32'(k == 7));
        end
        wr(6'h00, 32'h0);
        check("exp0_count_wrap", 32'(n_exp0), 32'd3);

        // Unmapped reads, rdata hold, mod_en gating.
        rd(6'h3C, 32'd0, "rd_ch3");
        rd(6'h2C, 32'd0, "rd_ch2");
        rd(6'h1C, 32'd1, "stat1_again");
        repeat (3) @(negedge clk);
        check("rdata_hold", rdata, 32'd1);
        addr   = 6'h3C;
        mod_en = 1'b0;
        rd_en  = 1'b1;
        @(negedge clk);
        rd_en  = 1'b0;
        mod_en = 1'b1;
        check("rdata_gated", rdata, 32'd1);
        wr(6'h14, 32'h55, 1'b0);
        wr(6'h34, 32'h77);
        rd(6'h14, 32'd2, "max1_kept");

        // Reset mid-count with CNT=5; accesses during reset are ignored.
        wr(6'h08, 32'd5);
        wr(6'h04, 32'h20);
        wr(6'h00, 32'h5);
        rst    = 1'b1;
        addr   = 6'h10;
        wdata  = 32'h1;
        wr_en  = 1'b1;
        rd_en  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("expire_in_rst", 32'(expire), 32'd0);
        end
        check("rdata_after_rst", rdata, 32'd0);
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("expire_post_rst%0d", k), 32'(expire), 32'd0);
        end
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 4; r++) begin
                rd(6'(ch * 16 + r * 4), 32'd0, $sformatf("ch%0d_reg%0d_post_rst", ch, r));
            end
        end
        repeat (5) @(negedge clk);
        rd(6'h08, 32'd0, "cnt0_stopped");
        check("irq_post_rst", 32'(irq), 32'd0);
        check("exp0_count_final", 32'(n_exp0), 32'd3);

        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_channels.md
TIMER_CHANNELS -- requirements
Module: timer_channels

Interface
REQ-001 Parameter N_CH, default 2: number of independent timer channels, legal 1..4.
REQ-002 Parameter CNT_W, default 16: counter and max-value width, legal 8..32.
REQ-003 clk  input  1  single clock; all logic SHALL be sampled on its rising edge.
REQ-004 rst  input  1  reset; SHALL be synchronous and active-high.
REQ-005 addr  input  6  byte address; channel c occupies 0x10*c..0x10*c+0xC.
REQ-006 wr_en  input  1  write strobe.
REQ-007 rd_en  input  1  read strobe.
REQ-008 mod_en  input  1  module select; SHALL gate both wr_en and rd_en.
REQ-009 wdata  input  32  write data.
REQ-010 rdata  output  32  read data, registered.
REQ-011 irq  output  N_CH  per-channel level interrupt.
REQ-012 expire  output  N_CH  per-channel one-cycle expiry pulse.

Function
REQ-013 Register map per channel c, offset from 0x10*c: CTRL 0x0, MAX 0x4, CNT 0x8, STAT 0xC.
REQ-014 CTRL bits: [0] en, [1] mode (0 periodic, 1 one-shot), [2] irq_en, [15:8] presc; all other bits SHALL read 0.
REQ-015 A write SHALL occur when wr_en & mod_en are high and addr hits a mapped register of a channel < N_CH; all other writes SHALL be ignored.
REQ-016 A read SHALL occur when rd_en & mod_en are high; rdata SHALL update on the next clock edge (1-cycle latency) and SHALL otherwise hold its value.
REQ-017 Reads of unmapped addresses or channels >= N_CH SHALL return 0.
REQ-018 MAX and CNT writes SHALL take wdata[CNT_W-1:0]; reads SHALL zero-extend to 32 bits.
REQ-019 Per channel: an 8-bit prescaler SHALL count 0..presc while en=1, generating one tick in the cycle it equals presc, then wrapping to 0; presc=0 SHALL tick every cycle.
REQ-020 A CTRL write that sets en from 0 to 1 SHALL clear the prescaler; en=0 SHALL freeze CNT and the prescaler.
REQ-021 On tick with CNT != MAX, CNT SHALL increment by 1.
REQ-022 On tick with CNT == MAX: CNT SHALL become 0, expire[c] SHALL pulse high for exactly that following cycle, and STAT[0] SHALL set.
REQ-023 One-shot mode: on expiry, en SHALL clear in the same edge; periodic mode: en SHALL stay set.
REQ-024 MAX=0 SHALL expire on every tick.
REQ-025 MAX lowered below current CNT: CNT SHALL continue incrementing and wrap modulo 2^CNT_W to 0 without expiry, then count to MAX normally.
REQ-026 STAT[0] SHALL be sticky, cleared by writing 1 (W1C); writing 0 SHALL have no effect.
REQ-027 Expiry and STAT W1C in the same cycle: set SHALL win.
REQ-028 CNT write and tick in the same cycle: the write SHALL win and no expiry SHALL be generated.
REQ-029 MAX write and tick in the same cycle: comparison SHALL use the old MAX.
REQ-030 irq[c] SHALL equal STAT[0] & irq_en, registered-free (combinational from flops).
REQ-031 Channels SHALL be fully independent; activity on one SHALL not affect another.

Reset
REQ-032 While rst=1 on a clock edge: all CTRL, MAX, CNT, STAT, prescalers, rdata, expire SHALL become 0; irq SHALL be 0.
REQ-033 rst asserted mid-count SHALL abort counting with no expire pulse in the reset cycle or after.
REQ-034 Register accesses coincident with rst=1 SHALL be ignored.

Verification
REQ-035 Ch0 MAX=3, CTRL=0x5 (en, periodic, irq_en, presc 0) -> CNT 0,1,2,3,0...; expire[0] every 4 cycles; irq[0]=1 after first expiry.
REQ-036 Ch1 MAX=2, CTRL=0x0203 (one-shot, presc 2) -> tick every 3 cycles, single expire[1] after 9 cycles, CTRL[0] reads 0, CNT=0.
REQ-037 STAT W1C issued in the same cycle as an expiry -> STAT[0] reads 1; a later W1C alone -> reads 0, irq deasserts.
REQ-038 CNT write 0x10 coinciding with CNT==MAX tick -> CNT reads 0x10, no expire pulse.
REQ-039 Read addr 0x3C with N_CH=2 -> rdata 0 one cycle later; write with mod_en=0 -> no register change.
REQ-040 rst pulse during periodic count with CNT=5 -> all registers read 0, no expire, counting stays stopped.
